ila_capture_ctrl: RTL
=====================

# ila_capture_ctrl

Capture controller for the ILA, directly downstream of the trigger generator. It consumes the generator's one-cycle `trigger` pulse and records `probe_data` into a circular sample buffer. The recording holds pre-trigger history plus a programmable number of post-trigger samples. Once the capture is frozen, the buffer is read back through a registered read port.

## Interface
Parameters:
- DATA_WIDTH, 32, probe sample width
- ADDR_WIDTH, 8, buffer address width; depth D = 2**ADDR_WIDTH

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- arm  in  1  start (or restart) a capture; level sampled each cycle
- trigger  in  1  one-cycle pulse from the trigger generator
- probe_data  in  DATA_WIDTH  sample written every capturing cycle
- post_count  in  ADDR_WIDTH  post-trigger samples; latched on arm
- rd_addr  in  ADDR_WIDTH  absolute buffer read address
- rd_data  out  DATA_WIDTH  registered read data
- busy  out  1  high in ARMED or POST
- done  out  1  capture frozen
- trig_addr  out  ADDR_WIDTH  address holding the trigger-cycle sample
- start_addr  out  ADDR_WIDTH  address of the oldest valid sample
- valid_depth  out  ADDR_WIDTH+1  number of valid samples, 1..D

## Operation
- States: IDLE, ARMED, POST, DONE.
- IDLE:
  - No writes.
  - On arm: go to ARMED, set wr_ptr=0 and fill=0, latch post_count into remaining.
- ARMED:
  - Each cycle writes mem[wr_ptr] <= probe_data, increments wr_ptr mod D, and increments fill (saturating at D).
  - On trigger, that same cycle's sample is the trigger sample and trig_addr <= wr_ptr.
  - After the trigger: go to DONE if remaining==0, else go to POST.
- POST:
  - Writes continue each cycle and remaining decrements.
  - The cycle that writes with remaining==1 transitions to DONE.
- DONE:
  - No writes.
  - Outputs hold until the next arm or reset.
- Completion outputs:
  - valid_depth = fill, saturated at D.
  - start_addr = (fill==D) ? wr_ptr : 0, where wr_ptr is the next-write pointer at freeze.
- Arm in any state aborts the current capture and restarts at ARMED. done clears on the next edge.
- Arm and trigger in the same cycle: arm wins and the trigger is ignored.
- Trigger in IDLE, POST or DONE is ignored.
- Wrap-around: wr_ptr wraps silently. If post_count wraps past trig_addr, the trigger sample is overwritten, which is legal.
- Reading:
  - rd_data <= mem[rd_addr] every cycle in every state.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
- Reset mid-capture:
  - Returns to IDLE and clears all outputs.
  - Buffer contents are not cleared.

## Timing
- Reset values: busy=0, done=0, trig_addr=0, start_addr=0, valid_depth=0, rd_data=0.
- Arm sampled at edge N: busy=1 from N+1, and the first sample is written at edge N+1.
- Trigger sampled at edge T with post_count=P: the last write happens at edge T+P, and done=1 and busy=0 are visible after edge T+P.
- rd_data latency is one cycle from rd_addr.

## Configuration
- ILA_CAPTURE_TIMESTAMP_EN defined:
  - Adds output trig_timestamp[31:0].
  - A 32-bit cycle counter clears on arm and increments each cycle in ARMED/POST.
  - trig_timestamp latches the counter value on the accepted trigger and holds it until the next arm or reset.
  - Reset value is 0.
  - Wrap at 2**32 is silent.
- Not defined: the port, counter and latch are absent. Behaviour is otherwise identical.

## Structure
- Shared package ila_pkg:
  - State enum (IDLE=0, ARMED=1, POST=2, DONE=3).
  - Default DATA_WIDTH and ADDR_WIDTH constants.
- Sub-module ila_sample_ram:
  - Simple dual-port synchronous RAM.
  - One write port, one registered read port, read-before-write, no reset on the array.
- Controller FSM, pointers and counters stay in ila_capture_ctrl.

## Test plan
- Arm, 20 idle cycles, trigger, post_count=5 (D=256, probe_data = cycle count): done 5 cycles after trigger, valid_depth=26, start_addr=0, trig_addr=20, rd_addr=20 returns the trigger-cycle value.
- Arm, 300 cycles, trigger, post_count=10: valid_depth=256, start_addr = wr_ptr at freeze = (300+11) mod 256 = 55, and the trigger sample is read back at trig_addr.
- post_count=0: done on the edge after the trigger, and the trigger sample is the last write.
- Arm and trigger asserted together: state stays ARMED with no capture. A later trigger at cycle 7 gives trig_addr=7.
- Reset during POST: next cycle busy=0, done=0, valid_depth=0. A later trigger with no arm is ignored.
- With ILA_CAPTURE_TIMESTAMP_EN: arm, trigger 42 cycles later, then trig_timestamp=42. Re-arm clears it.

Source files
------------

// File: rtl/ila_pkg.sv
// Shared types and defaults for the ILA capture path.
package ila_pkg;

    localparam int ILA_DATA_WIDTH = 32;
    localparam int ILA_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } ila_state_e;

endpackage

// File: rtl/ila_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module ila_sample_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ila_capture_ctrl.sv
// ILA capture controller: records probe_data around a trigger into a circular buffer.
// Optional ILA_CAPTURE_TIMESTAMP_EN adds a trigger timestamp output.
module ila_capture_ctrl
    import ila_pkg::*;
#(
    parameter int DATA_WIDTH = ILA_DATA_WIDTH,
    parameter int ADDR_WIDTH = ILA_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic [DATA_WIDTH-1:0] probe_data,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH:0]   valid_depth
`ifdef ILA_CAPTURE_TIMESTAMP_EN
   ,output logic [31:0]           trig_timestamp
`endif
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

    ila_state_e            state;
    ila_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   fill;
    logic [ADDR_WIDTH-1:0] remaining;
    logic                  load;
    logic                  capture;
    logic                  trig_hit;
    logic                  ram_we;

    // Arm overrides everything, including a same-cycle trigger.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        trig_hit  = 1'b0;
        if (arm) begin
            state_nxt = ARMED;
            load      = 1'b1;
        end else begin
            case (state)
                ARMED: begin
                    capture = 1'b1;
                    if (trigger) begin
                        trig_hit  = 1'b1;
                        state_nxt = (remaining == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    capture = 1'b1;
                    if (remaining == ADDR_WIDTH'(1)) begin
                        state_nxt = DONE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            remaining <= '0;
            trig_addr <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                wr_ptr    <= '0;
                fill      <= '0;
                remaining <= post_count;
                trig_addr <= '0;
            end else begin
                if (capture) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill != FULL) begin
                        fill <= fill + 1'b1;
                    end
                end
                if (trig_hit) begin
                    trig_addr <= wr_ptr;
                end
                if (state == POST) begin
                    remaining <= remaining - 1'b1;
                end
            end
        end
    end

`ifdef ILA_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt         <= '0;
            trig_timestamp <= '0;
        end else if (load) begin
            ts_cnt         <= '0;
            trig_timestamp <= '0;
        end else begin
            if (capture) begin
                ts_cnt <= ts_cnt + 32'd1;
            end
            if (trig_hit) begin
                trig_timestamp <= ts_cnt;
            end
        end
    end
`endif

    // Once frozen, wr_ptr and fill stop moving, so the completion outputs derive from them.
    assign busy        = (state == ARMED) || (state == POST);
    assign done        = (state == DONE);
    assign valid_depth = done ? fill : '0;
    assign start_addr  = (done && (fill == FULL)) ? wr_ptr : '0;
    assign ram_we      = capture && !reset;

    ila_sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .we      (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (probe_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
